// File: rtl/uart_tx_fifo_regs.sv
// UART transmitter with TX FIFO and CTRL/DATA/STATUS/LEVEL registers; parity only with `UART_TX_PARITY_EN.
// rd_data one cycle after rd_en; pushes into a full FIFO are dropped and flagged as STATUS.ovf.

// Circular FIFO; pushes while full are refused, clr empties it in one cycle.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          push, pop;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign push   = wr_vld & ~full;
  assign pop    = rd_rdy & ~empty;
  assign rd_dat = mem[rd_ptr];
  assign level  = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

module uart_tx_fifo_regs #(
  parameter int CLKS_PER_BIT = 3,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       tx_out
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic              two_stop_q, two_stop_nxt;
  logic              tx_nxt, pop, done_pls, bit_end, start_ok, busy;

  logic              tx_en, par_en, par_odd, two_stop;
  logic              done_flag, ovf_flag;
  logic              wr_ctrl, push_vld, fifo_clr, ovf_set, rd_ok, rd_status;
  logic [7:0]        rd_mux;

  logic [DATA_W-1:0] fifo_dat;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;

  logic              unused_wr;
  assign unused_wr = ^wr_data;

  assign wr_ctrl   = wr_en && (wr_addr == 2'd0);
  assign push_vld  = wr_en && (wr_addr == 2'd1);
  assign fifo_clr  = wr_ctrl && wr_data[4];
  assign ovf_set   = push_vld && fifo_full;
  assign rd_ok     = rd_en && !wr_en;
  assign rd_status = rd_ok && (rd_addr == 2'd2);

  uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (fifo_clr),
    .wr_vld (push_vld),
    .wr_dat (wr_data[DATA_W-1:0]),
    .rd_rdy (pop),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_bit_q, par_bit_nxt;

  // Parity is computed from the whole character at load time, before shifting starts.
  assign par_bit_nxt = pop ? ((^fifo_dat) ^ par_odd) : par_bit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        par_en  <= wr_data[1];
        par_odd <= wr_data[2];
      end
      if (pop) par_en_q <= par_en;
      par_bit_q <= par_bit_nxt;
    end
  end
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
`endif

  assign bit_end  = (cnt == CNT_LAST);
  assign start_ok = tx_en && !fifo_empty;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    sh_nxt       = sh;
    two_stop_nxt = two_stop_q;
    pop          = 1'b0;
    done_pls     = 1'b0;
    tx_nxt       = 1'b1;
    if (state != S_IDLE) cnt_nxt = bit_end ? '0 : cnt + 1'b1;
    case (state)
      S_IDLE:  if (start_ok) pop = 1'b1;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          sh_nxt = sh >> 1;
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = par_en_q ? S_PARITY : S_STOP;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_nxt = S_STOP;
`endif
      S_STOP: begin
        if (bit_end) begin
          if (two_stop_q && idx == '0) begin
            idx_nxt = IDX_W'(1);
          end else begin
            done_pls = 1'b1;
            if (start_ok) pop = 1'b1;
            else          state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Loading a character always restarts the frame, whether from IDLE or straight out of STOP.
    if (pop) begin
      state_nxt    = S_START;
      cnt_nxt      = '0;
      idx_nxt      = '0;
      sh_nxt       = fifo_dat;
      two_stop_nxt = two_stop;
    end
    // tx_out is registered from the next state so the line changes on the same edge as the FSM.
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = sh_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_nxt = par_bit_nxt;
`endif
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      two_stop_q <= 1'b0;
      tx_out     <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      sh         <= sh_nxt;
      two_stop_q <= two_stop_nxt;
      tx_out     <= tx_nxt;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      2'd0:    rd_mux = {4'b0, two_stop, par_odd, par_en, tx_en};
      2'd2:    rd_mux = {3'b0, ovf_flag, fifo_empty, fifo_full, done_flag, busy};
      2'd3:    rd_mux = 8'(fifo_level);
      default: rd_mux = '0;
    endcase
  end

  // Sticky flags: a set in the same cycle as the clearing STATUS read is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en     <= 1'b0;
      two_stop  <= 1'b0;
      done_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (wr_ctrl) begin
        tx_en    <= wr_data[0];
        two_stop <= wr_data[3];
      end
      done_flag <= done_pls | (done_flag & ~rd_status);
      ovf_flag  <= ovf_set | (ovf_flag & ~rd_status);
      if (rd_ok) rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_regs.sv
// Directed + randomized bench for uart_tx_fifo_regs against a frame/queue reference model.
module tb_uart_tx_fifo_regs;
  localparam int CPB   = 3;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, tx_out;
  logic [1:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         exp_bits[$];
  logic [7:0] mq[$];

  always #5 clk = ~clk;

  uart_tx_fifo_regs #(.CLKS_PER_BIT(CPB), .DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tx_out  (tx_out)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Push into the DUT and into the model queue (dropped when the model is full).
  task automatic push(input logic [7:0] d);
    wr(2'd1, d);
    if (mq.size() < DEPTH) mq.push_back(d);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    chk(tag, rd_data, exp);
  endtask

  // Bit i of a frame: start, 8 data bits LSB first, optional parity, then stop bits.
  function automatic bit fbit(input logic [7:0] d, input bit pe, input bit po, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (pe && i == 9) return (^d) ^ po;
    return 1'b1;
  endfunction

  task automatic add_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts);
    for (int i = 0; i < 10 + int'(pe) + int'(ts); i++) exp_bits.push_back(fbit(d, pe, po, i));
  endtask

  task automatic check_stream(input string tag);
    bit b;
    while (exp_bits.size() > 0) begin
      b = exp_bits.pop_front();
      repeat (CPB) begin
        chk(tag, 8'(tx_out), 8'(b));
        step();
      end
    end
  endtask

  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 8'(tx_out), 8'h01);
      step();
    end
  endtask

  initial begin
    bit         pe, po, ts;
    int         n;
    logic [7:0] cfg, d0;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;

    // Reset dominance under random bus activity
    repeat (100) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = 2'($urandom);
      rd_addr = 2'($urandom);
      wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rst_tx", 8'(tx_out), 8'h01);
    chk("rst_rd", rd_data, 8'h00);
    rst = 1'b0;
    rd_chk("rst_status", 2'd2, 8'h08);
    rd_chk("rst_level", 2'd3, 8'h00);
    rd_chk("rst_ctrl", 2'd0, 8'h00);

    // Single frame
    wr(2'd0, 8'h01);
    push(8'hA5);
    chk("sf_pre", 8'(tx_out), 8'h01);
    step();
    add_frame(mq.pop_front(), 1'b0, 1'b0, 1'b0);
    check_stream("sf_bits");
    idle_chk("sf_idle", 2);
    rd_chk("sf_status1", 2'd2, 8'h0A);
    rd_chk("sf_status2", 2'd2, 8'h08);

    // Write wins over a simultaneous read; rd_data holds
    rd_chk("pri_ctrl", 2'd0, 8'h01);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h01; rd_en = 1'b1; rd_addr = 2'd2;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("pri_hold", rd_data, 8'h01);

    // Overflow then back-to-back drain
    wr(2'd0, 8'h00);
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
    rd_chk("ovf_level", 2'd3, 8'(mq.size()));
    rd_chk("ovf_status", 2'd2, 8'h14);
    rd_chk("ovf_status2", 2'd2, 8'h04);
    wr(2'd0, 8'h01);
    step();
    while (mq.size() > 0) add_frame(mq.pop_front(), 1'b0, 1'b0, 1'b0);
    check_stream("b2b_bits");
    idle_chk("b2b_idle", 3);
    rd_chk("b2b_level", 2'd3, 8'h00);
    rd_chk("b2b_status", 2'd2, 8'h0A);

    // Parity configuration
`ifdef UART_TX_PARITY_EN
    wr(2'd0, 8'h07);
    rd_chk("par_ctrl", 2'd0, 8'h07);
    push(8'h03);
    step();
    add_frame(mq.pop_front(), 1'b1, 1'b1, 1'b0);
    check_stream("par_odd_bits");
    idle_chk("par_idle", 2);
    wr(2'd0, 8'h0B);
    push(8'h03);
    step();
    add_frame(mq.pop_front(), 1'b1, 1'b0, 1'b1);
    check_stream("par_even2_bits");
`else
    wr(2'd0, 8'h07);
    rd_chk("par_ctrl", 2'd0, 8'h01);
    push(8'h03);
    step();
    add_frame(mq.pop_front(), 1'b0, 1'b0, 1'b0);
    check_stream("nopar_bits");
`endif
    idle_chk("par_idle2", 2);
    rd_chk("par_status", 2'd2, 8'h0A);

    // Randomized framing and burst length
    for (int it = 0; it < 6; it++) begin
      pe  = HAS_PAR ? 1'($urandom_range(0, 1)) : 1'b0;
      po  = HAS_PAR ? 1'($urandom_range(0, 1)) : 1'b0;
      ts  = 1'($urandom_range(0, 1));
      cfg = {4'b0, ts, po, pe, 1'b0};
      wr(2'd0, cfg);
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) push(8'($urandom));
      wr(2'd0, cfg | 8'h01);
      step();
      while (mq.size() > 0) add_frame(mq.pop_front(), pe, po, ts);
      check_stream("rnd_bits");
      rd_chk("rnd_status", 2'd2, 8'h0A);
    end

    // Disable mid-frame, then clear the FIFO
    wr(2'd0, 8'h00);
    for (int k = 0; k < 3; k++) push(8'($urandom));
    wr(2'd0, 8'h01);
    step();
    add_frame(mq.pop_front(), 1'b0, 1'b0, 1'b0);
    fork
      check_stream("en_bits");
      begin
        repeat (3) step();
        wr(2'd0, 8'h00);
      end
    join
    idle_chk("en_idle", 6);
    rd_chk("en_level", 2'd3, 8'(mq.size()));
    wr(2'd0, 8'h10);
    mq.delete();
    rd_chk("clr_level", 2'd3, 8'h00);
    rd_chk("clr_ctrl", 2'd0, 8'h00);
    rd_chk("clr_status", 2'd2, 8'h0A);

    // Reset during data bit 3 (forced low so the abort is visible)
    wr(2'd0, 8'h00);
    push(8'($urandom) & 8'hF7);
    push(8'($urandom));
    wr(2'd0, 8'h01);
    d0 = mq[0];
    for (int c = 0; c < 13; c++) begin
      step();
      chk("rmf_bits", 8'(tx_out), 8'(fbit(d0, 1'b0, 1'b0, c / CPB)));
    end
    rst = 1'b1;
    step();
    chk("rmf_tx", 8'(tx_out), 8'h01);
    chk("rmf_rd", rd_data, 8'h00);
    rst = 1'b0;
    mq.delete();
    rd_chk("rmf_level", 2'd3, 8'h00);
    rd_chk("rmf_status", 2'd2, 8'h08);
    idle_chk("rmf_idle", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_regs.md
# uart_tx_fifo_regs

Parametrised UART transmitter with an integrated TX FIFO and a 4-entry register file, used as the microcontroller-facing TX port of the UART subsystem. Software configures framing through CTRL, pushes characters through DATA, and polls STATUS/LEVEL. Frames are serialised LSB-first on `tx_out` with configurable stop bits and optional parity. Queued characters go out back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, 3: clock cycles per serial bit, ≥1.
- `DATA_W`, 8: character width, 5..8; pushes use `wr_data[DATA_W-1:0]`.
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two, 2..128.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: register write strobe.
- `wr_addr` in 2: write address.
- `wr_data` in 8: write data.
- `rd_en` in 1: register read strobe.
- `rd_addr` in 2: read address.
- `rd_data` out 8: registered read data.
- `tx_out` out 1: serial line, idle high, registered.

## Operation
- Register map:
  - 0 CTRL (R/W):
    - bit0 `tx_en`.
    - bit1 `par_en`.
    - bit2 `par_odd`.
    - bit3 `two_stop`.
    - bit4 `fifo_clr`: write-1, self-clearing, reads 0.
    - bits 7:5 read 0.
  - 1 DATA (W): push to FIFO. Reads return 0.
  - 2 STATUS (R):
    - bit0 `busy`: FSM not IDLE.
    - bit1 `done`: sticky, set at the end of each frame.
    - bit2 `full`.
    - bit3 `empty`.
    - bit4 `ovf`: sticky, set when a push is dropped.
    - Reading STATUS clears `done` and `ovf`. A set event in the same cycle wins over the clear.
  - 3 LEVEL (R): FIFO occupancy, zero-extended.
- Write has priority: if `wr_en` and `rd_en` are both high, the read is ignored and `rd_data` holds.
- FIFO push/pop rules:
  - A push while `full` (evaluated pre-edge) is dropped and sets `ovf`, even if a pop occurs on the same edge.
  - Simultaneous push and pop when not full: LEVEL is unchanged.
  - `fifo_clr` empties the FIFO. It does not abort the frame in flight.
- FSM states: IDLE → START → DATA → PARITY (only if `par_en`) → STOP (1 or 2 bits) → IDLE or START.
  - IDLE → START when `tx_en` is set and the FIFO is not empty. The pop and the shift-register load happen on that edge.
  - DATA sends `DATA_W` bits, LSB first.
  - Parity bit = XOR of the data bits, inverted when `par_odd` is set.
  - Framing fields are latched at START. CTRL writes mid-frame affect the next frame only.
  - At the end of STOP: go to START directly if `tx_en` is set and the FIFO is not empty, otherwise go to IDLE. A 1-cycle internal `done` pulse sets STATUS.done.
  - Clearing `tx_en` mid-frame lets the current frame complete. No further pops occur.
- Bit counter counts 0..CLKS_PER_BIT-1. Bit index counter is sized for `DATA_W`. No wrap beyond the frame.
- Reset values:
  - `tx_out` = 1, `rd_data` = 0.
  - CTRL = 0, sticky flags = 0.
  - FIFO empty, FSM IDLE.
- Reset mid-frame aborts the frame. `tx_out` = 1 after the reset edge.

## Timing
- Write: takes effect at the `wr_en` edge.
- Read: `rd_data` is valid one cycle after the `rd_en` edge and holds until the next accepted read.
- With the FIFO empty, a push at edge N while `tx_en` is set gives START at edge N+1, so `tx_out` goes low 1 cycle after the push.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length = (1 + DATA_W + par_en + 1 + two_stop) × CLKS_PER_BIT cycles.
- STATUS.done is set on the edge after the last stop-bit cycle. It is visible on `rd_data` one read later.
- Back-to-back frames: the next start bit immediately follows the last stop-bit cycle, with zero idle cycles.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: `par_en` and `par_odd` are writable and the PARITY state exists.
- Undefined:
  - CTRL bits 1–2 read 0 and ignore writes.
  - The PARITY state and the parity logic are removed.
  - Frames are always start + data + stop(s).

## Test plan
All scenarios use CLKS_PER_BIT=3, DATA_W=8, FIFO_DEPTH=4.
- Reset dominance: `rst`=1 for 100 cycles with random `wr_en`/`rd_en`/addr/data each cycle -> `tx_out`=1, `busy`=0, `rd_data`=0, LEVEL=0 afterwards.
- Single frame:
  - Stimulus: CTRL=0x01, then push 0xA5.
  - `tx_out` goes low 1 cycle after the push.
  - Bits 0,1,0,1,0,0,1,0,1,1, 3 cycles each (30 cycles total).
  - STATUS reads 0x0A (done, empty), then 0x08 on a second read.
- Overflow and back-to-back:
  - With CTRL=0x00, push 0x11..0x15 -> LEVEL=4, STATUS=0x14 (full, ovf).
  - Re-read STATUS -> 0x04.
  - Set CTRL=0x01 -> 4 contiguous frames (120 cycles, no high gap between stop and start), 0x15 never sent.
- Parity (macro defined):
  - CTRL=0x07, push 0x03 -> parity bit 1, 33-cycle frame.
  - CTRL=0x0B, push 0x03 -> parity bit 0, two stop bits, 36 cycles.
  - Macro undefined: CTRL write 0x07 reads back 0x01, and the frame is 30 cycles.
- Enable and clear:
  - Queue 3 bytes, clear `tx_en` during the first data bit -> the first frame completes, `tx_out` stays 1, LEVEL=2.
  - Write CTRL=0x10 -> LEVEL=0, CTRL reads 0x00.
- Reset mid-frame: assert `rst` during data bit 3 with 2 bytes queued -> `tx_out`=1 on the next edge, and LEVEL=0, STATUS=0x08 after release.
